sipo_rx: RTL

Serial-in/parallel-out receiver that sits directly downstream of the 4-bit PISO serializer. It collects a bit-serial stream, MSB first, back into WIDTH-bit words. Each word is presented on a one-deep valid/ready output register. Framing (SIN_FIRST), mid-word resync and overflow detection make it the consumer half of the serial link.

---
 rtl/sipo_rx_pkg.sv | 29 ++
 rtl/sipo_rx_outreg.sv | 41 ++++
 rtl/sipo_rx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sipo_rx_pkg.sv
// Purpose: shared types and sizing helpers for the sipo_rx serial receiver.
// Contents: FSM state enum, default word width, count-width and frame-length helpers.
// Frame length grows by one parity bit when SIPO_RX_PARITY_EN is defined.
package sipo_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

`ifdef SIPO_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Bit counter must hold the full frame length without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

  // Serial bits per word on the wire, including the trailing parity bit if present.
  function automatic int frame_len(input int width);
    return width + PAR_BITS;
  endfunction

endpackage

// File: rtl/sipo_rx_outreg.sv
// Purpose: one-deep valid/ready holding register for assembled words, with sticky overflow.
// Latency: a word offered on word_vld is visible on dat/vld after the same clock edge.
// Backpressure: when full and not drained, the offered word is dropped and overflow is set.
// Ports: clk, rst_n (sync, active-low); word/word_vld offered word; ready consumer accept;
//        dat/vld held word; overflow sticky drop flag.
module sipo_rx_outreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] word,
  input  logic             word_vld,
  input  logic             ready,
  output logic [WIDTH-1:0] dat,
  output logic             vld,
  output logic             overflow
);

  logic accept;

  assign accept = vld && ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dat      <= '0;
      vld      <= 1'b0;
      overflow <= 1'b0;
    end else if (word_vld) begin
      // A drain in the same cycle frees the slot, so load instead of dropping.
      if (!vld || accept) begin
        dat <= word;
        vld <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (accept) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// Purpose: serial-in/parallel-out receiver, MSB first, framed by SIN_FIRST.
// Latency: DOUT_VALID rises on the edge that samples the last frame bit.
// Backpressure: none upstream; a word completing into a full, undrained output is dropped (OVERFLOW).
// Ports: CLK, RST_N (sync, active-low); SIN/SIN_VALID/SIN_FIRST serial input;
//        DOUT/DOUT_VALID/DOUT_READY word output; BUSY, OVERFLOW, FRAME_ERR, PAR_ERR status.
// Optional: SIPO_RX_PARITY_EN adds a trailing even-parity bit per frame and drives PAR_ERR.
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SIN,
  input  logic             SIN_VALID,
  input  logic             SIN_FIRST,
  output logic [WIDTH-1:0] DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic             BUSY,
  output logic             OVERFLOW,
  output logic             FRAME_ERR,
  output logic             PAR_ERR
);

  localparam int CW    = cnt_width(WIDTH);
  localparam int FRAME = frame_len(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] done_dat;
  logic             done;
  logic             busy_q;
  logic             frame_err_q;

  assign shifted = {sr[WIDTH-2:0], SIN};

  // The last bit of a frame without SIN_FIRST completes the word; SIN_FIRST there aborts instead.
  assign done = SIN_VALID && !SIN_FIRST && (state == SHIFT) && (count == LAST);

`ifdef SIPO_RX_PARITY_EN
  logic par_bad;
  logic par_err_q;

  // The final bit is parity, so the data bits are already fully shifted into sr.
  assign done_dat = sr;
  assign par_bad  = (^sr) ^ SIN;
  assign PAR_ERR  = par_err_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      par_err_q <= 1'b0;
    end else if (done && par_bad) begin
      par_err_q <= 1'b1;
    end
  end
`else
  assign done_dat = shifted;
  assign PAR_ERR  = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      count       <= '0;
      sr          <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (SIN_VALID) begin
      unique case (state)
        IDLE: begin
          // Bits arriving outside a frame are discarded until SIN_FIRST.
          if (SIN_FIRST) begin
            sr     <= {{(WIDTH-1){1'b0}}, SIN};
            count  <= CW'(1);
            state  <= SHIFT;
            busy_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (SIN_FIRST) begin
            // Resync: drop the partial word and start over with this bit.
            sr          <= {{(WIDTH-1){1'b0}}, SIN};
            count       <= CW'(1);
            frame_err_q <= 1'b1;
          end else if (done) begin
            sr     <= '0;
            count  <= '0;
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            sr    <= shifted;
            count <= count + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY      = busy_q;
  assign FRAME_ERR = frame_err_q;

  sipo_rx_outreg #(
    .WIDTH (WIDTH)
  ) u_outreg (
    .clk      (CLK),
    .rst_n    (RST_N),
    .word     (done_dat),
    .word_vld (done),
    .ready    (DOUT_READY),
    .dat      (DOUT),
    .vld      (DOUT_VALID),
    .overflow (OVERFLOW)
  );

endmodule
